hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller that drives the write-enable (`send`) and flush inputs of the IF/ID pipeline register, plus the PC write enable and the ID/EX bubble.
- Detects load-use hazards, taken branches resolved in ID, and multi-cycle data-memory misses in MEM.
- Issues the matching stall, flush or freeze controls.
- Keeps a saturating count of stalled cycles.

It sits beside the ID stage and is the single source of pipeline-advance control.

## Interface
- `MISS_LATENCY`, default 10: total frozen cycles per data-memory miss; must be ≥1.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `id_rs_i`  in  5  rs field of the instruction in IF/ID.
- `id_rt_i`  in  5  rt field of the instruction in IF/ID.
- `ex_memread_i`  in  1  instruction in ID/EX is a load.
- `ex_rd_i`  in  5  destination register of the instruction in ID/EX.
- `id_branch_i`  in  1  instruction in ID is a conditional branch.
- `id_eq_i`  in  1  branch condition true (taken) in ID.
- `mem_miss_i`  in  1  data access in MEM needs a multi-cycle fill.
- `pc_write_o`  out  1  1 = PC loads its next value.
- `if_id_send_o`  out  1  to the IF/ID `send` input; 1 = load, 0 = hold.
- `if_id_flush_o`  out  1  to the IF/ID flush input; 1 = clear to zero.
- `id_ex_bubble_o`  out  1  1 = ID/EX loads control zeros (NOP).
- `freeze_o`  out  1  1 = ID/EX, EX/MEM and MEM/WB hold their contents.
- `busy_o`  out  1  1 while in state MISS.
- `stall_cnt_o`  out  `CNT_W`  saturating count of cycles with `pc_write_o` = 0.

## Operation
Control outputs are combinational from state and inputs, so the pipeline registers act on them at the same edge. `state`, `miss_cnt` and `stall_cnt_o` are registered.

Hazard detection:
- Load-use hazard `lu` = `ex_memread_i` & (`ex_rd_i` ≠ 0) & (`ex_rd_i` = `id_rs_i` | `ex_rd_i` = `id_rt_i`).
- Taken branch `tk` = `id_branch_i` & `id_eq_i`.

States: IDLE, MISS. Miss counter `miss_cnt` is ceil(log2(MISS_LATENCY+1)) bits wide.

Priority in IDLE (highest first):
1. `mem_miss_i`: freeze. Outputs: `pc_write_o`=0, `if_id_send_o`=0, `if_id_flush_o`=0, `id_ex_bubble_o`=0, `freeze_o`=1.
   - If MISS_LATENCY > 1: next state MISS, load `miss_cnt` = MISS_LATENCY−2.
   - If MISS_LATENCY = 1: stay in IDLE.
2. `lu`: load-use stall. Outputs: `pc_write_o`=0, `if_id_send_o`=0, `id_ex_bubble_o`=1, `if_id_flush_o`=0, `freeze_o`=0.
3. `tk`: flush. Outputs: `if_id_flush_o`=1, `pc_write_o`=1, `if_id_send_o`=1, `id_ex_bubble_o`=0, `freeze_o`=0.
4. Otherwise run. Outputs: `pc_write_o`=1, `if_id_send_o`=1, all others 0.

MISS state:
- Outputs as in freeze; `busy_o`=1.
- All inputs are ignored, including a new `mem_miss_i`, `lu` and `tk`.
- `miss_cnt` decrements each cycle. When `miss_cnt` = 0, next state is IDLE.
- A branch or load-use hazard present during a freeze is not lost. The instruction is still held in IF/ID and is re-evaluated in the first IDLE cycle.

Stall counter:
- `stall_cnt_o` increments on every edge where `pc_write_o` = 0.
- It holds at all-ones; there is no wrap.

## Timing
- Reset: state=IDLE, `miss_cnt`=0, `stall_cnt_o`=0.
- While `rst_i`=1, outputs are forced to run values: `pc_write_o`=1, `if_id_send_o`=1, `if_id_flush_o`=0, `id_ex_bubble_o`=0, `freeze_o`=0, `busy_o`=0.
- Reset asserted during MISS: abandons the miss and returns to IDLE at that edge.
- Load-use stall lasts exactly 1 cycle per hazard. On the next cycle the load has advanced, so `lu` deasserts unless a new load matches.
- Miss freeze lasts exactly MISS_LATENCY consecutive cycles: the detecting IDLE cycle plus MISS_LATENCY−1 cycles in MISS.
- The first cycle after a freeze is evaluated with the full IDLE priority.
- Flush is a 1-cycle pulse per evaluation. A branch held in ID across a stall flushes only once, in the first non-stalled cycle.
- Simultaneous conditions:
  - miss + lu + tk: freeze only.
  - lu + tk: stall only (branch operands not ready); flush occurs on the following cycle.

## Test plan
- Reset, then idle inputs for 3 cycles: `pc_write_o`=`if_id_send_o`=1, all other outputs 0, `stall_cnt_o`=0.
- Load-use: `ex_memread_i`=1, `ex_rd_i`=8, `id_rt_i`=8 for 1 cycle → one cycle with send=0, pc_write=0, bubble=1; `stall_cnt_o`=1.
- Same stimulus with `ex_rd_i`=0 → no stall.
- Taken branch: `id_branch_i`=1, `id_eq_i`=1 → `if_id_flush_o`=1 for 1 cycle, PC advances.
- With `id_eq_i`=0 → no flush.
- Miss with MISS_LATENCY=10, `mem_miss_i` pulsed for 1 cycle → `freeze_o`=1 and send=0 for exactly 10 cycles, `busy_o`=1 for the last 9; `stall_cnt_o` += 10.
- Second miss pulse mid-freeze → ignored, freeze still 10 cycles.
- Load-use and taken branch in the same cycle → stall cycle, then flush on the next cycle.
- Miss with branch in ID → 10 frozen cycles, then flush.
- `rst_i` asserted in the 4th MISS cycle → outputs return to run values the same cycle, IDLE next cycle, counter reads 0.
- Counter saturation with CNT_W=4 → after 20 stall cycles `stall_cnt_o`=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard/stall controller: load-use stall, branch flush,
//            data-miss freeze and saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MISS_LATENCY = 10,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_i,
    input  logic             id_eq_i,
    input  logic             mem_miss_i,
    output logic             pc_write_o,
    output logic             if_id_send_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             freeze_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MC_W = $clog2(MISS_LATENCY + 1);
    // The detecting IDLE cycle is the first frozen cycle, so MISS covers the rest.
    localparam logic [MC_W-1:0] c_miss_load =
        (MISS_LATENCY > 1) ? MC_W'(MISS_LATENCY - 2) : '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [MC_W-1:0]   r_miss_cnt;
    logic [MC_W-1:0]   w_next_miss_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_lu;
    logic              w_tk;

    assign w_lu = ex_memread_i && (ex_rd_i != 5'd0) &&
                  ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));
    assign w_tk = id_branch_i && id_eq_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_miss_cnt <= w_next_miss_cnt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_miss_cnt = r_miss_cnt;
        pc_write_o      = 1'b1;
        if_id_send_o    = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        freeze_o        = 1'b0;
        busy_o          = 1'b0;

        if (!rst_i) begin
            case (r_state)
                S_IDLE: begin
                    if (mem_miss_i) begin
                        pc_write_o   = 1'b0;
                        if_id_send_o = 1'b0;
                        freeze_o     = 1'b1;
                        if (MISS_LATENCY > 1) begin
                            w_next_state    = S_MISS;
                            w_next_miss_cnt = c_miss_load;
                        end
                    end else if (w_lu) begin
                        pc_write_o     = 1'b0;
                        if_id_send_o   = 1'b0;
                        id_ex_bubble_o = 1'b1;
                    end else if (w_tk) begin
                        if_id_flush_o = 1'b1;
                    end
                end
                S_MISS: begin
                    // Hazards are deliberately ignored here; the held IF/ID
                    // instruction is re-evaluated once back in IDLE.
                    pc_write_o   = 1'b0;
                    if_id_send_o = 1'b0;
                    freeze_o     = 1'b1;
                    busy_o       = 1'b1;
                    if (r_miss_cnt == '0) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_miss_cnt = r_miss_cnt - 1'b1;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (!pc_write_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire
